// File: rtl/dram_page_tracker.sv
// dram_page_tracker: classifies DRAM requests against a 16-entry open-row
// table (one entry per bank group / bank), hands each accepted request to
// dram_cmd with a one-cycle start pulse, and keeps saturating hit/miss/empty
// statistics.

package dram_page_tracker_pkg;
    typedef enum logic [1:0] {
        NULL  = 2'd0,
        HIT   = 2'd1,
        MISS  = 2'd2,
        EMPTY = 2'd3
    } dram_policy_t;
endpackage

module dram_page_tracker
    import dram_page_tracker_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_bg,
    input  logic [1:0]       req_bank,
    input  logic [ROW_W-1:0] req_row,
    input  logic             flush,
    input  logic             cmd_done,
    output logic             en,
    output dram_policy_t     POLICY,
    output logic             different_bg,
    output logic             different_b,
    output logic             busy,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] empty_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [15:0]        valid_r;
    logic [ROW_W-1:0]   row_r [16];
    logic               last_valid_r;
    logic [1:0]         last_bg_r;
    logic [1:0]         last_bank_r;

    logic               idle_s;
    logic               accept_s;
    logic               flush_s;
    logic [3:0]         idx_s;
    dram_policy_t       class_s;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign idle_s    = (state_r == ST_IDLE);
    // A flush in IDLE takes priority over any request in the same cycle.
    assign req_ready = idle_s && !flush;
    assign accept_s  = req_valid && req_ready;
    assign flush_s   = idle_s && flush;
    assign busy      = !idle_s;
    assign idx_s     = {req_bg, req_bank};

    // Classify the incoming request against its open-row entry.
    always_comb begin
        class_s = EMPTY;
        if (valid_r[idx_s]) begin
            if (row_r[idx_s] == req_row) begin
                class_s = HIT;
            end else begin
                class_s = MISS;
            end
        end else begin
            class_s = EMPTY;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: cmd_done only matters while waiting on dram_cmd.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_next_s = ST_WAIT;
            ST_WAIT: begin
                if (cmd_done) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Open-row table and previous-access registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 16'd0;
            last_valid_r <= 1'b0;
            last_bg_r    <= 2'd0;
            last_bank_r  <= 2'd0;
            for (int i = 0; i < 16; i++) begin
                row_r[i] <= {ROW_W{1'b0}};
            end
        end else if (flush_s) begin
            valid_r      <= 16'd0;
            last_valid_r <= 1'b0;
        end else if (accept_s) begin
            valid_r[idx_s] <= 1'b1;
            row_r[idx_s]   <= req_row;
            last_valid_r   <= 1'b1;
            last_bg_r      <= req_bg;
            last_bank_r    <= req_bank;
        end
    end

    // Registered outputs to dram_cmd: start pulse plus held classification.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en           <= 1'b0;
            POLICY       <= NULL;
            different_bg <= 1'b0;
            different_b  <= 1'b0;
        end else begin
            en <= accept_s;
            if (accept_s) begin
                POLICY       <= class_s;
                different_bg <= last_valid_r && (req_bg != last_bg_r);
                different_b  <= last_valid_r && (req_bank != last_bank_r);
            end else if ((state_r == ST_WAIT) && cmd_done) begin
                POLICY <= NULL;
            end
        end
    end

    // Saturating per-class statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= {CNT_W{1'b0}};
            miss_cnt  <= {CNT_W{1'b0}};
            empty_cnt <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            case (class_s)
                HIT:     hit_cnt   <= sat_inc(hit_cnt);
                MISS:    miss_cnt  <= sat_inc(miss_cnt);
                EMPTY:   empty_cnt <= sat_inc(empty_cnt);
                default: empty_cnt <= empty_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_page_tracker.sv
// Directed bench for dram_page_tracker: a default-width instance and a
// CNT_W=2 instance share one stimulus stream.
module tb_dram_page_tracker;
    import dram_page_tracker_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_bg = 2'd0;
    logic [1:0]  req_bank = 2'd0;
    logic [15:0] req_row = 16'd0;
    logic        flush = 1'b0;
    logic        cmd_done = 1'b0;

    logic         req_ready, en, different_bg, different_b, busy;
    dram_policy_t policy;
    logic [15:0]  hit_cnt, miss_cnt, empty_cnt;

    logic         s_req_ready, s_en, s_dbg, s_db, s_busy;
    dram_policy_t s_policy;
    logic [1:0]   s_hit, s_miss, s_empty;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_page_tracker dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .flush(flush),
        .cmd_done(cmd_done), .en(en), .POLICY(policy), .different_bg(different_bg),
        .different_b(different_b), .busy(busy), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .empty_cnt(empty_cnt)
    );

    dram_page_tracker #(.ROW_W(16), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_bg(req_bg), .req_bank(req_bank), .req_row(req_row), .flush(flush),
        .cmd_done(cmd_done), .en(s_en), .POLICY(s_policy), .different_bg(s_dbg),
        .different_b(s_db), .busy(s_busy), .hit_cnt(s_hit),
        .miss_cnt(s_miss), .empty_cnt(s_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full request: accept, ISSUE cycle, WAIT cycle, cmd_done back to IDLE.
    task automatic do_req(input string tag, input logic [1:0] bg, input logic [1:0] bank,
                          input logic [15:0] row, input dram_policy_t exp_pol,
                          input logic exp_dbg, input logic exp_db);
        @(negedge clk);
        req_valid = 1'b1; req_bg = bg; req_bank = bank; req_row = row;
        #1;
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, "_en"}, {31'd0, en}, 32'd1);
        chk({tag, "_policy"}, {30'd0, policy}, {30'd0, exp_pol});
        chk({tag, "_dbg"}, {31'd0, different_bg}, {31'd0, exp_dbg});
        chk({tag, "_db"}, {31'd0, different_b}, {31'd0, exp_db});
        @(posedge clk); #1;
        chk({tag, "_en_low"}, {31'd0, en}, 32'd0);
        chk({tag, "_busy_wait"}, {31'd0, busy}, 32'd1);
        chk({tag, "_policy_held"}, {30'd0, policy}, {30'd0, exp_pol});
        cmd_done = 1'b1;
        @(posedge clk); #1;
        cmd_done = 1'b0;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_policy_null"}, {30'd0, policy}, {30'd0, NULL});
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_policy", {30'd0, policy}, {30'd0, NULL});
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
        chk("rst_empty", {16'd0, empty_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // First request to an empty table
        do_req("r1", 2'd0, 2'd0, 16'd5, EMPTY, 1'b0, 1'b0);
        chk("r1_empty_cnt", {16'd0, empty_cnt}, 32'd1);

        // Same row hits, different row misses
        do_req("r2", 2'd0, 2'd0, 16'd5, HIT, 1'b0, 1'b0);
        do_req("r3", 2'd0, 2'd0, 16'd9, MISS, 1'b0, 1'b0);
        chk("r3_hit_cnt", {16'd0, hit_cnt}, 32'd1);
        chk("r3_miss_cnt", {16'd0, miss_cnt}, 32'd1);

        // Bank group change, then bank change
        do_req("r4", 2'd2, 2'd0, 16'd7, EMPTY, 1'b1, 1'b0);
        do_req("r5", 2'd2, 2'd3, 16'd7, EMPTY, 1'b0, 1'b1);
        chk("r5_empty_cnt", {16'd0, empty_cnt}, 32'd3);

        // Flush wins over a simultaneous request
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_bg = 2'd0; req_bank = 2'd0; req_row = 16'd5;
        #1;
        chk("fl_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_en", {31'd0, en}, 32'd0);
        flush = 1'b0; req_valid = 1'b0;
        do_req("r6", 2'd0, 2'd0, 16'd5, EMPTY, 1'b0, 1'b0);
        chk("r6_hit_cnt", {16'd0, hit_cnt}, 32'd1);
        chk("r6_empty_cnt", {16'd0, empty_cnt}, 32'd4);

        // Reset asserted in WAIT with req_valid held high throughout
        @(negedge clk);
        req_valid = 1'b1; req_bg = 2'd0; req_bank = 2'd0; req_row = 16'd5;
        @(posedge clk); #1;
        chk("rw_issue_pol", {30'd0, policy}, {30'd0, HIT});
        @(posedge clk); #2;
        chk("rw_in_wait", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rw_policy", {30'd0, policy}, {30'd0, NULL});
        chk("rw_busy", {31'd0, busy}, 32'd0);
        chk("rw_en", {31'd0, en}, 32'd0);
        chk("rw_cnts", {hit_cnt, empty_cnt}, 32'd0);
        chk("rw_miss", {16'd0, miss_cnt}, 32'd0);
        chk("rw_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rw_post_en", {31'd0, en}, 32'd1);
        chk("rw_post_pol", {30'd0, policy}, {30'd0, EMPTY});
        chk("rw_post_dbg", {31'd0, different_bg}, 32'd0);
        chk("rw_post_db", {31'd0, different_b}, 32'd0);
        chk("rw_post_empty", {16'd0, empty_cnt}, 32'd1);
        @(posedge clk); #1;
        cmd_done = 1'b1;
        @(posedge clk); #1;
        cmd_done = 1'b0;
        chk("rw_done", {31'd0, busy}, 32'd0);

        // Saturation: five hits on a 2-bit counter stick at 3
        for (int i = 0; i < 5; i++) begin
            do_req("sat", 2'd0, 2'd0, 16'd5, HIT, 1'b0, 1'b0);
        end
        chk("sat_small_hit", {30'd0, s_hit}, 32'd3);
        chk("sat_small_empty", {30'd0, s_empty}, 32'd1);
        chk("sat_big_hit", {16'd0, hit_cnt}, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
